// File: rtl/dnn_aggr_ctrl.sv
// Control and aggregation end of the 2-node DNN datapath: sequences both
// compute nodes through LAYER1 -> AGGR -> FINAL_OUT, sums their layer-1 ReLU
// outputs per hidden neuron, broadcasts the sums back and reports done/err.

package defines_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAYER1    = 2'd1,
        AGGR      = 2'd2,
        FINAL_OUT = 2'd3
    } dnn_state_t;
endpackage

module dnn_aggr_ctrl
    import defines_pkg::*;
#(
    parameter int L1_WAIT     = 2,
    parameter int OUT_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_ready,
    input  logic signed [12:0] y4_n0_relu,
    input  logic signed [12:0] y5_n0_relu,
    input  logic signed [12:0] y6_n0_relu,
    input  logic signed [12:0] y7_n0_relu,
    input  logic signed [12:0] y4_n1_relu,
    input  logic signed [12:0] y5_n1_relu,
    input  logic signed [12:0] y6_n1_relu,
    input  logic signed [12:0] y7_n1_relu,
    input  logic               out0_n0_ready,
    input  logic               out1_n0_ready,
    input  logic               out0_n1_ready,
    input  logic               out1_n1_ready,
    output dnn_state_t         dnn_state,
    output logic signed [14:0] y4_n0_aggr,
    output logic signed [14:0] y5_n0_aggr,
    output logic signed [14:0] y6_n0_aggr,
    output logic signed [14:0] y7_n0_aggr,
    output logic signed [14:0] y4_n1_aggr,
    output logic signed [14:0] y5_n1_aggr,
    output logic signed [14:0] y6_n1_aggr,
    output logic signed [14:0] y7_n1_aggr,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // One counter serves both the LAYER1 wait and the FINAL_OUT timeout.
    localparam int CNT_MAX = (L1_WAIT > OUT_TIMEOUT) ? L1_WAIT : OUT_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] L1_LAST = CNT_W'(L1_WAIT - 1);
    // Counter is 0 in the first FINAL_OUT cycle, so OUT_TIMEOUT-1 marks the
    // last permitted cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(OUT_TIMEOUT - 1);

    dnn_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic signed [12:0] cap_n0 [4];
    logic signed [12:0] cap_n1 [4];
    logic signed [14:0] aggr_q [4];
    logic signed [14:0] aggr_sum [4];
    logic signed [12:0] relu_n0 [4];
    logic signed [12:0] relu_n1 [4];
    logic               all_ready;

    assign relu_n0[0] = y4_n0_relu;
    assign relu_n0[1] = y5_n0_relu;
    assign relu_n0[2] = y6_n0_relu;
    assign relu_n0[3] = y7_n0_relu;
    assign relu_n1[0] = y4_n1_relu;
    assign relu_n1[1] = y5_n1_relu;
    assign relu_n1[2] = y6_n1_relu;
    assign relu_n1[3] = y7_n1_relu;

    assign all_ready = out0_n0_ready & out1_n0_ready & out0_n1_ready & out1_n1_ready;

    // Per-neuron signed sum of the captured node values, widened to 15 bits.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            aggr_sum[k] = 15'({{2{cap_n0[k][12]}}, cap_n0[k]})
                        + 15'({{2{cap_n1[k][12]}}, cap_n1[k]});
        end
    end

    // Main controller: state, counter, ReLU capture, aggregated outputs, done/err.
    // NOTE: the capture and aggregate arrays are only a few registers, so they
    // are reset along with the FSM to give defined outputs straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                cap_n0[k] <= '0;
                cap_n1[k] <= '0;
                aggr_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout so every register
            // updates from the pre-edge values; done defaults low to pulse.
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_ready) begin
                        state <= LAYER1;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end
                end
                LAYER1: begin
                    if (cnt == L1_LAST) begin
                        state <= AGGR;
                        cnt   <= '0;
                        for (int k = 0; k < 4; k++) begin
                            cap_n0[k] <= relu_n0[k];
                            cap_n1[k] <= relu_n1[k];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                AGGR: begin
                    state <= FINAL_OUT;
                    cnt   <= '0;
                    for (int k = 0; k < 4; k++) begin
                        aggr_q[k] <= aggr_sum[k];
                    end
                end
                FINAL_OUT: begin
                    // Success is checked first so it wins over a coincident timeout.
                    if (all_ready) begin
                        state <= IDLE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else if (cnt == TO_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dnn_state = state;
    assign busy      = (state != IDLE);

    // Both nodes receive identical aggregated values.
    assign y4_n0_aggr = aggr_q[0];
    assign y5_n0_aggr = aggr_q[1];
    assign y6_n0_aggr = aggr_q[2];
    assign y7_n0_aggr = aggr_q[3];
    assign y4_n1_aggr = aggr_q[0];
    assign y5_n1_aggr = aggr_q[1];
    assign y6_n1_aggr = aggr_q[2];
    assign y7_n1_aggr = aggr_q[3];

endmodule
